ps2_keyboard: RTL

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver and scan-code decoder.
//
// Synchronizes the raw PS/2 clock and data lines and detects PS/2 clock
// falling edges. Each 11-bit frame (start, 8 data LSB first, odd parity,
// stop) is received, and the accepted byte is decoded: E0 and F0 are
// prefixes that only set internal flags; any other byte is a key event that
// is published together with the accumulated prefix flags.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   ps2_clk       raw PS/2 clock (asynchronous to clk)
//   ps2_data      raw PS/2 data (asynchronous to clk)
//   key[7:0]      scan code of the last key event
//   key_released  last event was a break (F0 prefix)
//   extended      last event carried an E0 prefix
//   done          one-cycle pulse when key/key_released/extended update
//   parity_err    one-cycle pulse on a rejected frame (only with the macro)
//
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad
// odd parity or a zero stop bit and to add the parity_err port.
//
// Frame FSM:
//   state  | meaning
//   IDLE   | waiting for a start bit (falling edge with data 0)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | next edge carries the parity bit
//   STOP   | next edge carries the stop bit; byte is accepted here

module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_released,
  output logic       extended,
  output logic       done
`ifdef PS2_PARITY_CHECK_EN
  ,
  output logic       parity_err
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;
  logic bit_in;

  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic [TO_W-1:0] to_cnt;
  logic            brk, ext;
  logic            timeout_hit;
  logic            frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
`endif

  // Synchronizers preset to 1 (idle bus level) so reset release never looks
  // like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall        = clk_s3 & ~clk_s2;
  assign bit_in      = dat_s2;
  assign timeout_hit = (state_q != IDLE) && (to_cnt == TO_MAX);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity over data+parity means the 9-bit XOR must be 1.
  assign frame_ok = (^{shift_q, par_q}) & bit_in;
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= 3'd0;
      shift_q      <= 8'd0;
      to_cnt       <= '0;
      brk          <= 1'b0;
      ext          <= 1'b0;
      key          <= 8'd0;
      key_released <= 1'b0;
      extended     <= 1'b0;
      done         <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif

      if (state_q == IDLE || fall)
        to_cnt <= '0;
      else if (!timeout_hit)
        to_cnt <= to_cnt + 1'b1;

      if (timeout_hit) begin
        // Abandon the partial byte; prefix flags and outputs are kept.
        bit_cnt <= 3'd0;
        shift_q <= 8'd0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!bit_in) begin
              bit_cnt <= 3'd0;
              shift_q <= 8'd0;
            end
          end
          DATA: begin
            shift_q <= {bit_in, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q <= bit_in;
`endif
          end
          STOP: begin
            if (frame_ok) begin
              if (shift_q == 8'hE0) begin
                ext <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                key          <= shift_q;
                key_released <= brk;
                extended     <= ext;
                done         <= 1'b1;
                brk          <= 1'b0;
                ext          <= 1'b0;
              end
            end
`ifdef PS2_PARITY_CHECK_EN
            else begin
              parity_err <= 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
